// File: rtl/event_encoder_pkg.sv
// Shared types and helpers for the event encoder.
// Round-robin picking is enabled by defining EVENT_ENCODER_ROUND_ROBIN_EN.
package event_encoder_pkg;

    localparam int N_IN_DEFAULT = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } enc_state_e;

    function automatic int lowest_set_idx(input logic [63:0] v);
        int r;
        r = 0;
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    // Rotate the low n bits of v right by amt; bits at or above n are cleared.
    function automatic logic [63:0] rotate_right(
        input logic [63:0] v,
        input int          amt,
        input int          n
    );
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < n) r[i] = v[(i + amt) % n];
        end
        return r;
    endfunction

endpackage

// File: rtl/event_encoder_8_to_3_prio_enc.sv
// Combinational priority encoder whose search starts at start_idx
// and wraps; with start_idx=0 it is a plain lowest-index-first encoder.
module prio_enc_n
    import event_encoder_pkg::*;
#(
    parameter int N     = N_IN_DEFAULT,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     cand,
    input  logic [IDX_W-1:0] start_idx,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [63:0] rot;
    int          rel;

    always_comb begin
        rot = rotate_right(64'(cand), int'(start_idx), N);
        rel = lowest_set_idx(rot);
        idx = IDX_W'((rel + int'(start_idx)) % N);
        any = |cand;
    end

endmodule

// File: rtl/event_encoder_8_to_3.sv
// Multi-hot event vector to a stream of binary indices over valid/ready.
// Define EVENT_ENCODER_ROUND_ROBIN_EN for rotating priority.
module event_encoder_8_to_3
    import event_encoder_pkg::*;
#(
    parameter  int N_IN  = N_IN_DEFAULT,
    localparam int IDX_W = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [N_IN-1:0]  in,
    output logic [IDX_W-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_IN-1:0]  pending,
    output logic             overflow
);

    enc_state_e       state_q;
    logic [N_IN-1:0]  pending_q;
    logic [IDX_W-1:0] out_q;
    logic             overflow_q;

    logic [N_IN-1:0]  cap;
    logic [N_IN-1:0]  cand;
    logic [N_IN-1:0]  take;
    logic [IDX_W-1:0] start_idx;
    logic [IDX_W-1:0] pick;
    logic             any;
    logic             fire;
    logic             slot_free;
    logic             lost;

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_q;
    assign start_idx = IDX_W'(last_q + 1'b1);
`else
    assign start_idx = '0;
`endif

    prio_enc_n #(
        .N     (N_IN),
        .IDX_W (IDX_W)
    ) u_prio (
        .cand      (cand),
        .start_idx (start_idx),
        .idx       (pick),
        .any       (any)
    );

    assign out_valid = (state_q == FULL);
    assign out       = out_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

    always_comb begin
        cap       = en ? in : '0;
        cand      = pending_q | cap;
        fire      = out_valid & out_ready;
        slot_free = ~out_valid | fire;
        take      = (slot_free && any) ? (N_IN'(1) << pick) : '0;
        // A repeat on an already-queued bit is lost unless it moves into the slot.
        lost      = |(cap & pending_q & ~take);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            pending_q  <= '0;
            out_q      <= '0;
            overflow_q <= 1'b0;
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
            last_q     <= IDX_W'(N_IN - 1);
`endif
        end else if (clr) begin
            state_q    <= EMPTY;
            pending_q  <= '0;
            out_q      <= '0;
            overflow_q <= 1'b0;
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
            last_q     <= IDX_W'(N_IN - 1);
`endif
        end else begin
            pending_q <= cand & ~take;
            if (lost) overflow_q <= 1'b1;
            if (slot_free) begin
                if (any) begin
                    state_q <= FULL;
                    out_q   <= pick;
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
                    last_q  <= pick;
`endif
                end else begin
                    state_q <= EMPTY;
                end
            end
        end
    end

endmodule

// File: tb/tb_event_encoder_8_to_3.sv
// Directed and random checks of event_encoder_8_to_3 against a
// behavioural queue model of pending events and the output slot.
module tb_event_encoder_8_to_3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       clr = 1'b0;
    logic [7:0] in = '0;
    logic [2:0] out;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] pending;
    logic       overflow;

    int vectors = 0;
    int errors  = 0;

    bit m_pend [8];
    bit m_valid;
    int m_out;
    bit m_ovf;
    int m_last;

    event_encoder_8_to_3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .in        (in),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_valid = 1'b0;
        m_out   = 0;
        m_ovf   = 1'b0;
        m_last  = 7;
    endtask

    function automatic logic [7:0] m_pend_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_edge();
        bit cand [8];
        bit capb [8];
        int start;
        int pick;
        if (clr) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 8; i++) begin
            capb[i] = en && in[i];
            cand[i] = m_pend[i] || capb[i];
        end
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
        start = (m_last + 1) % 8;
`else
        start = 0;
`endif
        pick = -1;
        if (!m_valid || out_ready) begin
            for (int k = 0; k < 8; k++) begin
                if (pick < 0 && cand[(start + k) % 8]) pick = (start + k) % 8;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (capb[i] && m_pend[i] && i != pick) m_ovf = 1'b1;
        end
        if (!m_valid || out_ready) m_valid = (pick >= 0);
        if (pick >= 0) begin
            m_out  = pick;
            m_last = pick;
        end
        for (int i = 0; i < 8; i++) m_pend[i] = cand[i] && (i != pick);
    endtask

    task automatic compare_all();
        check("out_valid", {7'b0, out_valid}, {7'b0, m_valid});
        check("pending", pending, m_pend_vec());
        check("overflow", {7'b0, overflow}, {7'b0, m_ovf});
        if (m_valid) check("out", {5'b0, out}, 8'(m_out));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    int exp_seq [3];

    initial begin
        model_reset();
        #12;
        check("rst out", {5'b0, out}, 8'h00);
        check("rst valid", {7'b0, out_valid}, 8'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // pending=A5 then asynchronous reset mid-cycle
        out_ready = 1'b0;
        in = 8'h01;
        tick();
        in = 8'hA5;
        tick();
        check("pend A5", pending, 8'hA5);
        in = 8'h00;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async out", {5'b0, out}, 8'h00);
        check("async valid", {7'b0, out_valid}, 8'h00);
        check("async pend", pending, 8'h00);
        check("async ovf", {7'b0, overflow}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        tick();
        tick();

        // single event
        in = 8'h10;
        tick();
        check("single out", {5'b0, out}, 8'h04);
        in = 8'h00;
        tick();
        check("single done", {7'b0, out_valid}, 8'h00);

        // multi-hot drain
        in = 8'b1001_0110;
        tick();
        check("drain 1", {5'b0, out}, 8'h01);
        in = 8'h00;
        exp_seq = '{2, 4, 7};
        for (int k = 0; k < 3; k++) begin
            tick();
            check("drain seq", {5'b0, out}, 8'(exp_seq[k]));
        end
        tick();
        check("drain end", {7'b0, out_valid}, 8'h00);

        // backpressure
        out_ready = 1'b0;
        in = 8'b1001_0110;
        tick();
        in = 8'h00;
        for (int k = 0; k < 4; k++) tick();
        check("bp out", {5'b0, out}, 8'h01);
        check("bp pend", pending, 8'b1001_0100);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp seq", {5'b0, out}, 8'(exp_seq[k]));
        end
        tick();

        // overflow / merge
        out_ready = 1'b0;
        in = 8'h06;
        tick();
        in = 8'h04;
        tick();
        check("ovf set", {7'b0, overflow}, 8'h01);
        in = 8'h00;
        out_ready = 1'b1;
        tick();
        check("ovf one 2", {5'b0, out}, 8'h02);
        tick();
        check("ovf empty", {7'b0, out_valid}, 8'h00);
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // re-pulse of the presented index
        out_ready = 1'b0;
        in = 8'h02;
        tick();
        tick();
        check("repulse ovf", {7'b0, overflow}, 8'h00);
        in = 8'h00;
        out_ready = 1'b1;
        tick();
        check("repulse again", {5'b0, out}, 8'h01);
        tick();

        // en low and clr
        en = 1'b0;
        in = 8'hFF;
        tick();
        check("en low", {7'b0, out_valid}, 8'h00);
        en = 1'b1;
        out_ready = 1'b0;
        in = 8'h0F;
        tick();
        in = 8'h00;
        clr = 1'b1;
        in = 8'hFF;
        tick();
        check("clr pend", pending, 8'h00);
        check("clr valid", {7'b0, out_valid}, 8'h00);
        clr = 1'b0;
        in = 8'h00;
        out_ready = 1'b1;

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
        in = 8'h03;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr alt", {5'b0, out}, 8'(k % 2));
        end
        in = 8'h00;
        tick();
        tick();
`endif

        // random traffic
        for (int k = 0; k < 400; k++) begin
            in        = 8'($urandom);
            en        = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clr       = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
